// File: rtl/dcache_fill_unit.sv
// dcache_fill_unit: data-cache line refill engine.
// Takes one line miss at a time, reads the line from the memory bus beat by
// beat, assembles it, then offers it to the dcache pipeline fill port until the
// arbiter grants it. o_done pulses one cycle after the grant so the LSU can
// replay any loads that were waiting on this line.

module dcache_fill_unit #(
  parameter int OPTN_DATA_WIDTH    = 32,
  parameter int OPTN_ADDR_WIDTH    = 32,
  parameter int OPTN_DC_CACHE_SIZE = 1024,
  parameter int OPTN_DC_LINE_SIZE  = 32,
  parameter int OPTN_DC_WAY_COUNT  = 1,
  parameter int OPTN_BEAT_WIDTH    = 32,
  localparam int DC_LINE_WIDTH     = OPTN_DC_LINE_SIZE * 8,
  localparam int DC_OFFSET_WIDTH   = $clog2(OPTN_DC_LINE_SIZE),
  localparam int DC_SET_COUNT      = OPTN_DC_CACHE_SIZE / (OPTN_DC_LINE_SIZE * OPTN_DC_WAY_COUNT),
  localparam int DC_INDEX_WIDTH    = $clog2(DC_SET_COUNT),
  localparam int DC_TAG_WIDTH      = OPTN_ADDR_WIDTH - DC_INDEX_WIDTH - DC_OFFSET_WIDTH
) (
  input  logic                       clk,
  input  logic                       n_rst,

  input  logic                       i_miss_valid,
  input  logic [OPTN_ADDR_WIDTH-1:0] i_miss_addr,
  output logic                       o_miss_ready,

  output logic                       o_bus_req_valid,
  output logic [OPTN_ADDR_WIDTH-1:0] o_bus_req_addr,
  input  logic                       i_bus_req_ready,
  input  logic                       i_bus_data_valid,
  input  logic [OPTN_BEAT_WIDTH-1:0] i_bus_data,

  output logic                       o_fill,
  output logic [DC_TAG_WIDTH-1:0]    o_fill_tag,
  output logic [DC_INDEX_WIDTH-1:0]  o_fill_index,
  output logic                       o_fill_valid,
  output logic                       o_fill_dirty,
  output logic [DC_LINE_WIDTH-1:0]   o_fill_data,
  input  logic                       i_fill_grant,

  output logic                       o_busy,
  output logic [OPTN_ADDR_WIDTH-1:0] o_busy_addr,
  output logic                       o_done
);

  localparam int BEATS          = DC_LINE_WIDTH / OPTN_BEAT_WIDTH;
  localparam int BEAT_CNT_WIDTH = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [BEAT_CNT_WIDTH-1:0] LAST_BEAT = BEAT_CNT_WIDTH'(BEATS - 1);

  // Clears the byte-offset bits so every stored address is line aligned.
  localparam logic [OPTN_ADDR_WIDTH-1:0] OFFSET_MASK =
    {{(OPTN_ADDR_WIDTH - DC_OFFSET_WIDTH){1'b0}}, {DC_OFFSET_WIDTH{1'b1}}};

  // A beat width that does not tile the line would leave holes in the fill data.
  if (((DC_LINE_WIDTH % OPTN_BEAT_WIDTH) != 0) || (OPTN_DATA_WIDTH < 1)) begin : g_param_check
    $error("dcache_fill_unit: OPTN_BEAT_WIDTH must divide the line width");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RECV = 2'd2,
    FILL = 2'd3
  } fill_state_t;

  fill_state_t state_q;
  fill_state_t state_d;

  logic [OPTN_ADDR_WIDTH-1:0]                 addr_q;
  logic [BEATS-1:0][OPTN_BEAT_WIDTH-1:0]      line_q;
  logic [BEAT_CNT_WIDTH-1:0]                  cnt_q;
  logic                                       done_q;

  logic miss_take;
  logic beat_take;
  logic last_beat;
  logic grant_take;

  assign miss_take  = (state_q == IDLE) && i_miss_valid;
  assign beat_take  = (state_q == RECV) && i_bus_data_valid;
  assign last_beat  = beat_take && (cnt_q == LAST_BEAT);
  assign grant_take = (state_q == FILL) && i_fill_grant;

  // State register; reset aborts any refill in flight.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore outputs; bus data seen outside RECV is simply ignored.
  always_comb begin
    state_d         = state_q;
    o_miss_ready    = 1'b0;
    o_bus_req_valid = 1'b0;
    o_fill          = 1'b0;
    o_busy          = 1'b1;
    case (state_q)
      IDLE: begin
        o_miss_ready = 1'b1;
        o_busy       = 1'b0;
        if (i_miss_valid) begin
          state_d = REQ;
        end
      end
      REQ: begin
        o_bus_req_valid = 1'b1;
        if (i_bus_req_ready) begin
          state_d = RECV;
        end
      end
      RECV: begin
        if (last_beat) begin
          state_d = FILL;
        end
      end
      FILL: begin
        o_fill = 1'b1;
        if (i_fill_grant) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Beat counter and completion pulse; the pulse marks the cycle after the grant.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= grant_take;
      if (miss_take) begin
        cnt_q <= '0;
      end else if (beat_take) begin
        if (last_beat) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  // Address and line storage are not reset; they are only read once refilled.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      if (miss_take) begin
        addr_q <= i_miss_addr & ~OFFSET_MASK;
      end
      if (beat_take) begin
        line_q[cnt_q] <= i_bus_data;
      end
    end
  end

  assign o_bus_req_addr = addr_q;
  assign o_busy_addr    = addr_q;
  assign o_fill_tag     = addr_q[OPTN_ADDR_WIDTH-1 -: DC_TAG_WIDTH];
  assign o_fill_index   = addr_q[DC_OFFSET_WIDTH +: DC_INDEX_WIDTH];
  assign o_fill_valid   = o_fill;
  assign o_fill_dirty   = 1'b0;
  assign o_fill_data    = line_q;
  assign o_done         = done_q;

endmodule
